// File: rtl/asp_irq_ctrl_pkg.sv
// CSR map and line-FSM state type for the ASP interrupt controller.
package asp_irq_ctrl_pkg;

  // Byte offsets of the CSRs; only address bits [5:3] are decoded
  localparam logic [5:0] CSR_OFF_STATUS = 6'h00;
  localparam logic [5:0] CSR_OFF_ENABLE = 6'h08;
  localparam logic [5:0] CSR_OFF_CLEAR  = 6'h10;
  localparam logic [5:0] CSR_OFF_RAW    = 6'h18;
  localparam logic [5:0] CSR_OFF_COUNT  = 6'h20;
  localparam logic [5:0] CSR_OFF_FORCE  = 6'h28;

  typedef enum logic [1:0] {
    IRQ_IDLE     = 2'd0,
    IRQ_REQ      = 2'd1,
    IRQ_WAIT_CLR = 2'd2
  } t_irq_line_state;

endpackage : asp_irq_ctrl_pkg

// File: rtl/dc_bsp_pkg.sv
// Board-level constants shared by the ASP blocks.
package dc_bsp_pkg;

  localparam int unsigned BSP_NUM_INTERRUPT_LINES = 4;
  localparam int unsigned BSP_AVMM_NUM_IRQ_USED   = 3;
  localparam int unsigned MMIO64_AVMM_ADDR_WIDTH  = 18;
  localparam int unsigned MMIO64_DATA_WIDTH       = 64;

  // Interrupt source bit positions on the ASP irq bus
  localparam int unsigned IRQ_DMA_0_BIT  = 0;
  localparam int unsigned IRQ_KERNEL_BIT = 1;
  localparam int unsigned IRQ_DMA_1_BIT  = 2;

endpackage : dc_bsp_pkg

// File: rtl/asp_irq_line_fsm.sv
// Per-vector delivery FSM: one host request per software clear of pending.
module asp_irq_line_fsm
  import asp_irq_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic i_pending,
  input  logic i_enable,
  input  logic i_ack,
  output logic o_req,
  output logic o_count_inc_c
);

  t_irq_line_state r_state;
  t_irq_line_state w_state_nxt;
  logic            r_req;

  // State register; req mirrors the REQ state so it is a clean flop output
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IRQ_IDLE;
      r_req   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_req   <= (w_state_nxt == IRQ_REQ);
    end
  end

  // Next-state: a raised request is held until the host acks it
  always_comb begin
    w_state_nxt   = r_state;
    o_count_inc_c = 1'b0;
    case (r_state)
      IRQ_IDLE: begin
        if (i_pending && i_enable) w_state_nxt = IRQ_REQ;
      end
      IRQ_REQ: begin
        if (i_ack) begin
          w_state_nxt   = IRQ_WAIT_CLR;
          o_count_inc_c = 1'b1;
        end
      end
      IRQ_WAIT_CLR: begin
        if (!i_pending) w_state_nxt = IRQ_IDLE;
      end
      default: w_state_nxt = IRQ_IDLE;
    endcase
  end

  assign o_req = r_req;

endmodule : asp_irq_line_fsm

// File: rtl/asp_irq_ctrl.sv
// ASP interrupt controller: edge capture, CSRs on MMIO64 AVMM, per-vector req/ack.
module asp_irq_ctrl
  import dc_bsp_pkg::*;
  import asp_irq_ctrl_pkg::*;
#(
  parameter int unsigned NUM_IRQ_LINES = BSP_NUM_INTERRUPT_LINES,
  parameter int unsigned NUM_IRQ_USED  = BSP_AVMM_NUM_IRQ_USED,
  parameter int unsigned ADDR_WIDTH    = MMIO64_AVMM_ADDR_WIDTH,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_IRQ_USED-1:0]        irq_in,
  input  logic [ADDR_WIDTH-1:0]          avmm_address,
  input  logic                           avmm_read,
  input  logic                           avmm_write,
  input  logic [MMIO64_DATA_WIDTH-1:0]   avmm_writedata,
  input  logic [MMIO64_DATA_WIDTH/8-1:0] avmm_byteenable,
  output logic [MMIO64_DATA_WIDTH-1:0]   avmm_readdata,
  output logic                           avmm_readdatavalid,
  output logic                           avmm_waitrequest,
  output logic [NUM_IRQ_LINES-1:0]       irq_req,
  input  logic [NUM_IRQ_LINES-1:0]       irq_ack
);

  localparam int unsigned DW       = MMIO64_DATA_WIDTH;
  localparam int unsigned BEW      = DW / 8;
  localparam int unsigned U        = NUM_IRQ_USED;
  localparam int unsigned CNT_BITS = NUM_IRQ_LINES * CNT_WIDTH;

  logic [U-1:0]             r_prev;
  logic [U-1:0]             r_pending;
  logic [U-1:0]             r_enable;
  logic                     r_waitreq;
  logic                     r_rdvalid;
  logic [DW-1:0]            r_rdata;

  logic                     w_rd_acc;
  logic                     w_wr_acc;
  logic [5:0]               w_off;
  logic [DW-1:0]            w_be_mask;
  logic [DW-1:0]            w_wbits;
  logic                     w_wr_enable;
  logic                     w_wr_clear;
  logic                     w_wr_force;
  logic                     w_wr_count;
  logic [U-1:0]             w_clr;
  logic [U-1:0]             w_force;
  logic [U-1:0]             w_rise;
  logic [DW-1:0]            w_rdata;
  logic [NUM_IRQ_LINES-1:0] w_req;
  logic [CNT_BITS-1:0]      w_count;
  logic                     w_unused;

  // Transactions are only accepted once waitrequest has dropped
  assign w_rd_acc = avmm_read  & ~r_waitreq;
  assign w_wr_acc = avmm_write & ~r_waitreq;
  assign w_off    = {avmm_address[5:3], 3'b000};

  // Expand byte enables into a bit mask
  always_comb begin
    w_be_mask = '0;
    for (int b = 0; b < BEW; b++) begin
      w_be_mask[b*8 +: 8] = {8{avmm_byteenable[b]}};
    end
  end

  assign w_wbits     = avmm_writedata & w_be_mask;
  assign w_wr_enable = w_wr_acc && (w_off == CSR_OFF_ENABLE);
  assign w_wr_clear  = w_wr_acc && (w_off == CSR_OFF_CLEAR);
  assign w_wr_force  = w_wr_acc && (w_off == CSR_OFF_FORCE);
  assign w_wr_count  = w_wr_acc && (w_off == CSR_OFF_COUNT);
  assign w_clr       = w_wr_clear ? w_wbits[U-1:0] : '0;
  assign w_force     = w_wr_force ? w_wbits[U-1:0] : '0;
  assign w_rise      = irq_in & ~r_prev;

  // Waitrequest held high through reset, released on the first cycle after
  always_ff @(posedge clk) begin
    if (!reset_n) r_waitreq <= 1'b1;
    else          r_waitreq <= 1'b0;
  end

  // Edge history, pending (set beats clear) and enable registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_prev    <= '0;
      r_pending <= '0;
      r_enable  <= '0;
    end else begin
      r_prev    <= irq_in;
      r_pending <= (r_pending & ~w_clr) | w_rise | w_force;
      if (w_wr_enable) begin
        r_enable <= (r_enable & ~w_be_mask[U-1:0]) | w_wbits[U-1:0];
      end
    end
  end

  // CSR read mux on pre-write register values
  always_comb begin
    w_rdata = '0;
    case (w_off)
      CSR_OFF_STATUS: w_rdata[U-1:0] = r_pending;
      CSR_OFF_ENABLE: w_rdata[U-1:0] = r_enable;
      CSR_OFF_RAW:    w_rdata[U-1:0] = irq_in;
      CSR_OFF_COUNT:  w_rdata        = DW'(w_count);
      default:        w_rdata        = '0;
    endcase
  end

  // One-cycle read response; readdata holds between reads
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rdvalid <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_rdvalid <= w_rd_acc;
      if (w_rd_acc) r_rdata <= w_rdata;
    end
  end

  // Per-line delivery FSM and saturating counter; unused lines tied off
  for (genvar i = 0; i < NUM_IRQ_LINES; i++) begin : g_line
    if (i < NUM_IRQ_USED) begin : g_used
      logic                 w_inc_c;
      logic [CNT_WIDTH-1:0] r_count;

      asp_irq_line_fsm u_fsm (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_pending     (r_pending[i]),
        .i_enable      (r_enable[i]),
        .i_ack         (irq_ack[i]),
        .o_req         (w_req[i]),
        .o_count_inc_c (w_inc_c)
      );

      // Delivery counter: cleared by any COUNT write, sticks at all-ones
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          r_count <= '0;
        end else if (w_wr_count) begin
          r_count <= '0;
        end else if (w_inc_c && (r_count != '1)) begin
          r_count <= r_count + CNT_WIDTH'(1);
        end
      end

      assign w_count[i*CNT_WIDTH +: CNT_WIDTH] = r_count;
    end else begin : g_tied
      assign w_req[i]                          = 1'b0;
      assign w_count[i*CNT_WIDTH +: CNT_WIDTH] = '0;
    end
  end

  assign avmm_readdata      = r_rdata;
  assign avmm_readdatavalid = r_rdvalid;
  assign avmm_waitrequest   = r_waitreq;
  assign irq_req            = w_req;

  // Address bits outside the decode, data above the used lines, acks of tied lines
  assign w_unused = ^{avmm_address[ADDR_WIDTH-1:6], avmm_address[2:0],
                      w_wbits[DW-1:U], irq_ack[NUM_IRQ_LINES-1:U]};

endmodule : asp_irq_ctrl

// File: tb/tb_asp_irq_ctrl.sv
// Self-checking bench for asp_irq_ctrl: directed sequences, vector table, random vs model.
module tb_asp_irq_ctrl;

  localparam int unsigned L    = 4;
  localparam int unsigned U    = 3;
  localparam int unsigned AW   = 18;
  localparam int unsigned CW   = 10;
  localparam int          CMAX = (1 << CW) - 1;

  localparam logic [2:0] S_STATUS = 3'd0;
  localparam logic [2:0] S_ENABLE = 3'd1;
  localparam logic [2:0] S_CLEAR  = 3'd2;
  localparam logic [2:0] S_RAW    = 3'd3;
  localparam logic [2:0] S_COUNT  = 3'd4;
  localparam logic [2:0] S_FORCE  = 3'd5;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [U-1:0]  irq_in;
  logic [AW-1:0] avmm_address;
  logic          avmm_read;
  logic          avmm_write;
  logic [63:0]   avmm_writedata;
  logic [7:0]    avmm_byteenable;
  logic [63:0]   avmm_readdata;
  logic          avmm_readdatavalid;
  logic          avmm_waitrequest;
  logic [L-1:0]  irq_req;
  logic [L-1:0]  irq_ack;

  always #5 clk = ~clk;

  asp_irq_ctrl #(
    .NUM_IRQ_LINES (L),
    .NUM_IRQ_USED  (U),
    .ADDR_WIDTH    (AW),
    .CNT_WIDTH     (CW)
  ) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .irq_in             (irq_in),
    .avmm_address       (avmm_address),
    .avmm_read          (avmm_read),
    .avmm_write         (avmm_write),
    .avmm_writedata     (avmm_writedata),
    .avmm_byteenable    (avmm_byteenable),
    .avmm_readdata      (avmm_readdata),
    .avmm_readdatavalid (avmm_readdatavalid),
    .avmm_waitrequest   (avmm_waitrequest),
    .irq_req            (irq_req),
    .irq_ack            (irq_ack)
  );

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    bit          is_wr;
    logic [2:0]  sel;
    logic [63:0] wdata;
    logic [7:0]  be;
    logic [63:0] exp;
  } vec_t;

  vec_t tbl[$];

  // Reference model: per line, whether a request is outstanding and whether the
  // line is waiting for software to clear pending before it may fire again.
  bit [U-1:0]  m_prev, m_pend, m_en, m_waitclr;
  bit [L-1:0]  m_req;
  int          m_cnt[L];
  logic [63:0] m_rdata;
  bit          m_rdv;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic csr_write(input logic [2:0] sel, input logic [63:0] data, input logic [7:0] be);
    avmm_address    = AW'({sel, 3'b000});
    avmm_writedata  = data;
    avmm_byteenable = be;
    avmm_write      = 1'b1;
    step();
    avmm_write      = 1'b0;
  endtask

  // Read with a check that the strobe is exactly one cycle wide
  task automatic csr_read_check(input string name, input logic [2:0] sel, input logic [63:0] exp);
    avmm_address = AW'({sel, 3'b000});
    avmm_read    = 1'b1;
    step();
    avmm_read    = 1'b0;
    check({name, "_rdv"}, 64'(avmm_readdatavalid), 64'd1);
    check(name, avmm_readdata, exp);
    step();
    check({name, "_rdv_end"}, 64'(avmm_readdatavalid), 64'd0);
  endtask

  task automatic ack_and_clear(input logic [L-1:0] lines, input logic [63:0] clr);
    irq_ack = lines;
    csr_write(S_CLEAR, clr, 8'hFF);
    irq_ack = '0;
  endtask

  task automatic wait_req(input string name, input int line, input int budget);
    int k = 0;
    while (!irq_req[line] && k < budget) begin
      step();
      k++;
    end
    if (!irq_req[line]) check({name, "_timeout"}, 64'(irq_req), 64'(1) << line);
  endtask

  function automatic logic [63:0] m_read(input logic [2:0] sel, input logic [U-1:0] irq);
    logic [63:0] v = '0;
    case (sel)
      S_STATUS: v = 64'(m_pend);
      S_ENABLE: v = 64'(m_en);
      S_RAW:    v = 64'(irq);
      S_COUNT:  for (int i = 0; i < L; i++) v |= 64'(m_cnt[i]) << (i * CW);
      default:  v = '0;
    endcase
    return v;
  endfunction

  task automatic model_reset();
    m_prev = '0; m_pend = '0; m_en = '0; m_waitclr = '0; m_req = '0;
    for (int i = 0; i < L; i++) m_cnt[i] = 0;
    m_rdata = '0; m_rdv = 1'b0;
  endtask

  // One clock of model behaviour given the inputs presented before the edge
  task automatic model_step(input logic [U-1:0] irq, input bit rd, input bit wr,
                            input logic [2:0] sel, input logic [63:0] wd,
                            input logic [7:0] be, input logic [L-1:0] ack);
    logic [U-1:0] wbits = be[0] ? wd[U-1:0] : '0;
    logic [U-1:0] rise  = irq & ~m_prev;
    logic [U-1:0] clr   = (wr && sel == S_CLEAR) ? wbits : '0;
    logic [U-1:0] frc   = (wr && sel == S_FORCE) ? wbits : '0;
    m_rdv = rd;
    if (rd) m_rdata = m_read(sel, irq);
    for (int i = 0; i < U; i++) begin
      if (m_req[i]) begin
        if (ack[i]) begin
          m_req[i]     = 1'b0;
          m_waitclr[i] = 1'b1;
          if (m_cnt[i] < CMAX) m_cnt[i]++;
        end
      end else if (m_waitclr[i]) begin
        if (!m_pend[i]) m_waitclr[i] = 1'b0;
      end else if (m_pend[i] && m_en[i]) begin
        m_req[i] = 1'b1;
      end
    end
    if (wr && sel == S_COUNT) for (int i = 0; i < L; i++) m_cnt[i] = 0;
    if (wr && sel == S_ENABLE && be[0]) m_en = wd[U-1:0];
    m_pend = (m_pend & ~clr) | rise | frc;
    m_prev = irq;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; irq_in = 3'b010; avmm_address = '0; avmm_read = 1'b0;
    avmm_write = 1'b0; avmm_writedata = '0; avmm_byteenable = 8'hFF; irq_ack = '0;

    // Reset values, then a level already high at release becomes one edge
    repeat (3) step();
    check("rst_irq_req", 64'(irq_req), 64'd0);
    check("rst_rdv", 64'(avmm_readdatavalid), 64'd0);
    check("rst_rdata", avmm_readdata, 64'd0);
    check("rst_wait", 64'(avmm_waitrequest), 64'd1);
    reset_n = 1'b1;
    step();
    check("rel_wait", 64'(avmm_waitrequest), 64'd0);
    csr_read_check("rel_status", S_STATUS, 64'h2);
    csr_read_check("rel_raw", S_RAW, 64'h2);
    check("rel_no_req", 64'(irq_req), 64'd0);

    // Line 0 delivery, ack, no re-request until cleared
    csr_write(S_CLEAR, 64'h2, 8'hFF);
    irq_in = '0;
    csr_write(S_ENABLE, 64'h7, 8'hFF);
    irq_in = 3'b001;
    step();
    irq_in = '0;
    check("l0_req_early", 64'(irq_req), 64'd0);
    step();
    check("l0_req", 64'(irq_req), 64'h1);
    irq_ack = 4'b0001;
    step();
    irq_ack = '0;
    check("l0_req_drop", 64'(irq_req), 64'd0);
    csr_read_check("l0_count1", S_COUNT, 64'd1);
    irq_in = 3'b001;
    step();
    irq_in = '0;
    for (int k = 0; k < 4; k++) begin
      step();
      check("l0_no_rereq", 64'(irq_req), 64'd0);
    end
    csr_read_check("l0_status_reset", S_STATUS, 64'h1);
    csr_write(S_CLEAR, 64'h1, 8'hFF);
    irq_in = 3'b001;
    step();
    irq_in = '0;
    check("l0_rereq_early", 64'(irq_req), 64'd0);
    step();
    check("l0_rereq", 64'(irq_req), 64'h1);
    ack_and_clear(4'b0001, 64'h1);
    check("l0_rereq_drop", 64'(irq_req), 64'd0);

    // Rise and clear on the same cycle: the set survives
    csr_write(S_ENABLE, 64'h0, 8'hFF);
    irq_in = 3'b100;
    csr_write(S_CLEAR, 64'h4, 8'hFF);
    irq_in = '0;
    csr_read_check("set_beats_clr", S_STATUS, 64'h4);
    csr_write(S_CLEAR, 64'h4, 8'hFF);
    csr_read_check("l2_cleared", S_STATUS, 64'h0);

    // FORCE across all four bits: bit 3 reads zero and never requests
    csr_write(S_FORCE, 64'hF, 8'hFF);
    csr_read_check("force_status", S_STATUS, 64'h7);
    csr_write(S_ENABLE, 64'hF, 8'hFF);
    csr_read_check("enable_masked", S_ENABLE, 64'h7);
    step();
    check("force_req", 64'(irq_req), 64'h7);
    csr_read_check("unmapped_30", 3'd6, 64'h0);
    check("force_req_hold", 64'(irq_req), 64'h7);
    ack_and_clear(4'b0111, 64'h7);
    check("force_req_drop", 64'(irq_req), 64'd0);
    csr_read_check("count_mix", S_COUNT, 64'd3 | (64'd1 << CW) | (64'd1 << (2 * CW)));
    csr_write(S_ENABLE, 64'h0, 8'hFF);

    // Vector table of CSR accesses from a fresh reset
    do_reset();
    tbl.push_back('{1'b1, S_ENABLE, 64'h5,                  8'hFF, 64'h0});
    tbl.push_back('{1'b0, S_ENABLE, 64'h0,                  8'hFF, 64'h5});
    tbl.push_back('{1'b1, S_ENABLE, 64'h2,                  8'h00, 64'h0});
    tbl.push_back('{1'b0, S_ENABLE, 64'h0,                  8'hFF, 64'h5});
    tbl.push_back('{1'b1, S_ENABLE, 64'h2,                  8'hFE, 64'h0});
    tbl.push_back('{1'b0, S_ENABLE, 64'h0,                  8'hFF, 64'h5});
    tbl.push_back('{1'b1, S_ENABLE, 64'hFFFF_FFFF_FFFF_FFFA, 8'h01, 64'h0});
    tbl.push_back('{1'b0, S_ENABLE, 64'h0,                  8'hFF, 64'h2});
    tbl.push_back('{1'b1, S_ENABLE, 64'h0,                  8'hFF, 64'h0});
    tbl.push_back('{1'b0, S_ENABLE, 64'h0,                  8'hFF, 64'h0});
    tbl.push_back('{1'b1, S_FORCE,  64'hF,                  8'hFF, 64'h0});
    tbl.push_back('{1'b0, S_STATUS, 64'h0,                  8'hFF, 64'h7});
    tbl.push_back('{1'b0, S_CLEAR,  64'h0,                  8'hFF, 64'h0});
    tbl.push_back('{1'b0, S_FORCE,  64'h0,                  8'hFF, 64'h0});
    tbl.push_back('{1'b1, S_CLEAR,  64'h5,                  8'h00, 64'h0});
    tbl.push_back('{1'b0, S_STATUS, 64'h0,                  8'hFF, 64'h7});
    tbl.push_back('{1'b1, S_CLEAR,  64'h5,                  8'hFF, 64'h0});
    tbl.push_back('{1'b0, S_STATUS, 64'h0,                  8'hFF, 64'h2});
    tbl.push_back('{1'b1, 3'd6,     64'hFF,                 8'hFF, 64'h0});
    tbl.push_back('{1'b0, 3'd6,     64'h0,                  8'hFF, 64'h0});
    tbl.push_back('{1'b0, 3'd7,     64'h0,                  8'hFF, 64'h0});
    tbl.push_back('{1'b0, S_COUNT,  64'h0,                  8'hFF, 64'h0});
    tbl.push_back('{1'b0, S_RAW,    64'h0,                  8'hFF, 64'h0});
    tbl.push_back('{1'b1, S_STATUS, 64'h0,                  8'hFF, 64'h0});
    tbl.push_back('{1'b0, S_STATUS, 64'h0,                  8'hFF, 64'h2});
    tbl.push_back('{1'b1, S_CLEAR,  64'h7,                  8'hFF, 64'h0});
    tbl.push_back('{1'b0, S_STATUS, 64'h0,                  8'hFF, 64'h0});
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].is_wr) csr_write(tbl[i].sel, tbl[i].wdata, tbl[i].be);
      else              csr_read_check($sformatf("vec%0d", i), tbl[i].sel, tbl[i].exp);
    end

    // Counter saturation on line 1, then clear by COUNT write
    csr_write(S_ENABLE, 64'h2, 8'hFF);
    for (int n = 1; n <= CMAX + 8; n++) begin
      csr_write(S_FORCE, 64'h2, 8'hFF);
      wait_req("sat_req", 1, 6);
      ack_and_clear(4'b0010, 64'h2);
      if (n == 1000) csr_read_check("count_1000", S_COUNT, 64'd1000 << CW);
    end
    csr_read_check("count_sat", S_COUNT, 64'(CMAX) << CW);
    csr_write(S_COUNT, 64'h1234, 8'hFF);
    csr_read_check("count_cleared", S_COUNT, 64'h0);

    // Reset while line 1 is requesting and a read is presented
    csr_write(S_FORCE, 64'h2, 8'hFF);
    wait_req("midrst_req", 1, 6);
    check("midrst_req_pre", 64'(irq_req), 64'h2);
    avmm_address = AW'({S_STATUS, 3'b000});
    avmm_read    = 1'b1;
    reset_n      = 1'b0;
    step();
    avmm_read    = 1'b0;
    check("midrst_req_drop", 64'(irq_req), 64'd0);
    check("midrst_no_rdv", 64'(avmm_readdatavalid), 64'd0);
    step();
    check("midrst_no_rdv2", 64'(avmm_readdatavalid), 64'd0);
    reset_n = 1'b1;
    step();
    csr_read_check("midrst_status", S_STATUS, 64'h0);
    csr_read_check("midrst_enable", S_ENABLE, 64'h0);
    csr_read_check("midrst_count", S_COUNT, 64'h0);
    csr_read_check("midrst_raw", S_RAW, 64'h0);

    // Random traffic against the reference model
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      logic [U-1:0] irq = irq_in ^ U'($urandom & $urandom);
      bit           rd  = ($urandom_range(0, 3) == 0);
      bit           wr  = ($urandom_range(0, 3) == 0);
      logic [2:0]   sel = 3'($urandom_range(0, 7));
      logic [63:0]  wd  = {$urandom, $urandom};
      logic [7:0]   be  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      logic [L-1:0] ack = '0;
      for (int i = 0; i < L; i++) begin
        if (i < U && m_req[i]) ack[i] = ($urandom_range(0, 2) == 0);
        else                   ack[i] = ($urandom_range(0, 15) == 0);
      end
      irq_in          = irq;
      avmm_read       = rd;
      avmm_write      = wr;
      avmm_address    = AW'({14'($urandom), sel, 3'($urandom)});
      avmm_writedata  = wd;
      avmm_byteenable = be;
      irq_ack         = ack;
      model_step(irq, rd, wr, sel, wd, be, ack);
      step();
      check("rnd_req", 64'(irq_req), 64'(m_req));
      check("rnd_rdv", 64'(avmm_readdatavalid), 64'(m_rdv));
      check("rnd_rdata", avmm_readdata, m_rdata);
    end
    avmm_read = 1'b0; avmm_write = 1'b0; irq_ack = '0;
    check("rnd_wait", 64'(avmm_waitrequest), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_asp_irq_ctrl

// File: doc/asp_irq_ctrl.md
Name: asp_irq_ctrl

Overview:
- Host-facing responder for the ASP interrupt sources: DMA_0, kernel and DMA_1.
- Captures rising edges on the per-source interrupt levels into pending bits.
- Delivers each enabled pending bit to the host interrupt path as a per-vector req/ack handshake.
- Exposes status, enable, clear, force and count CSRs on an MMIO64 AVMM responder port, decoded below board.qsys.

Parameters:
- NUM_IRQ_LINES, 4 (BSP_NUM_INTERRUPT_LINES): number of host vectors.
- NUM_IRQ_USED, 3 (BSP_AVMM_NUM_IRQ_USED): number of active sources. Lines at or above this index are tied inactive.
- ADDR_WIDTH, 18 (MMIO64_AVMM_ADDR_WIDTH): byte address width.
- CNT_WIDTH, 16: width of each per-line delivery counter. NUM_IRQ_LINES*CNT_WIDTH must be 64 or less.

Ports:
- clk  in  1  ASP clock
- reset_n  in  1  synchronous, active-low reset
- irq_in  in  NUM_IRQ_USED  source interrupt levels (bit0 DMA_0, bit1 kernel, bit2 DMA_1)
- avmm_address  in  ADDR_WIDTH  byte address; only bits [5:3] are decoded
- avmm_read  in  1  read request
- avmm_write  in  1  write request
- avmm_writedata  in  64  write data
- avmm_byteenable  in  8  byte enables
- avmm_readdata  out  64  read data
- avmm_readdatavalid  out  1  read response strobe
- avmm_waitrequest  out  1  backpressure
- irq_req  out  NUM_IRQ_LINES  per-vector interrupt request to host
- irq_ack  in  NUM_IRQ_LINES  per-vector acknowledge, one-cycle pulse

Behaviour:
- Clock and reset: one clock, clk. reset_n is synchronous and active-low.
- Values while reset_n is low:
  - readdata=0, readdatavalid=0, irq_req=0.
  - waitrequest=1, then 0 from the first cycle after reset_n rises.
  - pending, enable, counters and edge-history registers all 0.
  - All line FSMs in IDLE.
- Reset mid-operation: any asserted irq_req drops on the next clk edge. Outstanding reads are dropped, with no readdatavalid.
- Edge detect:
  - prev[i] <= irq_in[i] each cycle.
  - rise[i] = irq_in[i] & ~prev[i].
  - A line already high at reset release produces one edge on the first cycle.
- pending[i] is set by rise[i] or a FORCE write, and cleared by a CLEAR write.
  - A set and a clear on the same cycle: set wins, so no event is lost.
- CSR map (offset = address[5:3]*8); unmapped reads return 0, unmapped writes are ignored:
  - 0x00 STATUS, RO: pending bits.
  - 0x08 ENABLE, RW: reset 0.
  - 0x10 CLEAR, W1C on pending; reads 0.
  - 0x18 RAW, RO: irq_in levels.
  - 0x20 COUNT, RO: line i delivery count in bits [i*CNT_WIDTH +: CNT_WIDTH]. Any write clears all counters.
  - 0x28 FORCE, W1S on pending; reads 0.
- Writes honour byteenable. Bits at or above NUM_IRQ_USED are read-as-zero and write-ignored.
- Read handshake:
  - Read latency is exactly 1 cycle: readdatavalid pulses the cycle after a read is accepted.
  - readdata holds its last value otherwise.
  - Read and write asserted together: write takes effect, read returns the pre-write value.
- Per-line FSM (states IDLE, REQ, WAIT_CLR):
  - IDLE -> REQ when pending & enable. irq_req is asserted from the next cycle.
  - REQ -> WAIT_CLR on irq_ack. irq_req drops the same edge; the counter increments, saturating at all-ones.
  - A request is never retracted. Clearing pending or enable while in REQ has no effect until ack.
  - WAIT_CLR -> IDLE when pending = 0. This gives one host interrupt per software clear.
  - An edge arriving in REQ or WAIT_CLR re-sets pending. After software clears it, a new request follows only if pending is set again.
  - irq_ack seen while in IDLE or WAIT_CLR is ignored.
- Lines at or above NUM_IRQ_USED never request.

Decomposition:
- Use the existing dc_bsp_pkg for NUM_INTERRUPT_LINES, NUM_IRQ_USED, bit indices and MMIO64 width.
- New asp_irq_ctrl_pkg holds:
  - CSR offset localparams;
  - the line-FSM enum t_irq_line_state.
- Sub-module asp_irq_line_fsm, one instance per line.
  - Inputs: pending, enable, ack.
  - Outputs: req, count_inc.
- Edge detect, CSRs and read mux live in the top.

Test Plan:
- Reset release with irq_in=3'b010 -> STATUS=0x2 one cycle later, irq_req=0 because ENABLE=0, waitrequest low after reset.
- ENABLE=0x7, pulse irq_in[0] -> irq_req[0]=1 two cycles after the edge. Ack -> irq_req[0]=0, COUNT[15:0]=1. Second edge with no CLEAR -> no new req. CLEAR=0x1 then new edge -> req again.
- Same-cycle rise[2] and CLEAR=0x4 -> STATUS bit2 stays 1.
- FORCE=0xF -> STATUS=0x7 and bit3 never requests. Read of unmapped offset 0x30 -> 0, with readdatavalid exactly one cycle after read.
- Write ENABLE with byteenable=0x00 -> ENABLE unchanged. 65536 ack/clear cycles on line1 -> COUNT[31:16] saturates at 0xFFFF. Any COUNT write -> 0.
- reset_n low while irq_req[1]=1 and a read is in flight -> irq_req=0 next edge, no readdatavalid, all CSRs read 0 after release.
